uninasoc_irq_gateway: RTL

Receiving end of the platform interrupt lines: takes the raw PLIC source lines (GPIO-in, TIM0, TIM1, UART, HLS, …), synchronises them, gates each through a per-source pending/in-flight state machine and presents one claimable interrupt ID at a time to the PLIC target logic through a valid/ready claim port plus a complete port. It sits between the PBUS/HLS interrupt outputs and the PLIC core, and also drives the level request that becomes the core's external interrupt (cause 11).

---
 rtl/uninasoc_irq_gateway.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uninasoc_irq_gateway.sv
// Interrupt gateway: synchronises raw PLIC source lines, tracks IDLE/PENDING/IN_FLIGHT per source
// and offers one claimable ID at a time. Define IRQ_GATEWAY_EDGE_EN for per-source edge triggering.
module uninasoc_irq_gateway #(
    parameter int NUM_SOURCES = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
`ifdef IRQ_GATEWAY_EDGE_EN
    input  logic [NUM_SOURCES-1:0] edge_mode_i,
`endif
    output logic                   claim_valid_o,
    output logic [ID_WIDTH-1:0]    claim_id_o,
    input  logic                   claim_ready_i,
    input  logic                   complete_valid_i,
    input  logic [ID_WIDTH-1:0]    complete_id_i,
    output logic                   irq_o,
    output logic                   cpl_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PENDING   = 2'd1,
        ST_IN_FLIGHT = 2'd2
    } src_state_e;

    localparam logic [NUM_SOURCES-1:0] SRC_MASK = {{(NUM_SOURCES-1){1'b1}}, 1'b0};

    // Fixed priority: the lowest set bit above the reserved line 0 wins.
    function automatic logic [ID_WIDTH-1:0] lowest_id(input logic [NUM_SOURCES-1:0] vec);
        lowest_id = {ID_WIDTH{1'b0}};
        for (int i = NUM_SOURCES - 1; i >= 1; i--) begin
            if (vec[i]) begin
                lowest_id = ID_WIDTH'(i);
            end else begin
                lowest_id = lowest_id;
            end
        end
    endfunction

    logic [SYNC_STAGES-1:0][NUM_SOURCES-1:0] sync_q;
    logic [NUM_SOURCES-1:0] synced_s;
    logic [NUM_SOURCES-1:0] trig_s;
    logic [NUM_SOURCES-1:0] pend_s;
    logic [NUM_SOURCES-1:0] cpl_hit_s;
    logic [NUM_SOURCES-1:0] claim_mask_s;
    logic                   hs_s;

    src_state_e state_q [NUM_SOURCES];
    src_state_e state_d [NUM_SOURCES];

    logic                claim_valid_q, claim_valid_d;
    logic [ID_WIDTH-1:0] claim_id_q, claim_id_d;
    logic                irq_q, irq_d;
    logic                cpl_err_q, cpl_err_d;

    // Source line synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src_i & SRC_MASK};
        end
    end

    assign synced_s = sync_q[SYNC_STAGES-1];
    assign hs_s     = claim_valid_q & claim_ready_i;

`ifdef IRQ_GATEWAY_EDGE_EN
    logic [NUM_SOURCES-1:0] sync_prev_q;
    logic [NUM_SOURCES-1:0] edge_lat_q, edge_lat_d;

    // A claim consumes the remembered edge; a new edge (even during IN_FLIGHT) re-arms it once.
    assign edge_lat_d = ((edge_lat_q & ~claim_mask_s) | (synced_s & ~sync_prev_q & edge_mode_i)) & SRC_MASK;
    assign trig_s     = (edge_mode_i & edge_lat_q) | (~edge_mode_i & synced_s);

    // Edge detector history and edge latches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_prev_q <= '0;
            edge_lat_q  <= '0;
        end else begin
            sync_prev_q <= synced_s;
            edge_lat_q  <= edge_lat_d;
        end
    end
`else
    assign trig_s = synced_s;
`endif

    // Per-source status decode and claim/complete hit vectors.
    always_comb begin
        pend_s       = '0;
        cpl_hit_s    = '0;
        claim_mask_s = '0;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            pend_s[i]    = (state_q[i] == ST_PENDING);
            cpl_hit_s[i] = complete_valid_i && (complete_id_i == ID_WIDTH'(i))
                           && (state_q[i] == ST_IN_FLIGHT);
        end
        if (hs_s) begin
            claim_mask_s[claim_id_q] = 1'b1;
        end else begin
            claim_mask_s = '0;
        end
    end

    // Per-source next state; line 0 is pinned to IDLE.
    always_comb begin
        state_d[0] = ST_IDLE;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (trig_s[i]) state_d[i] = ST_PENDING;
                    else           state_d[i] = ST_IDLE;
                end
                ST_PENDING: begin
                    if (claim_mask_s[i]) state_d[i] = ST_IN_FLIGHT;
                    else                 state_d[i] = ST_PENDING;
                end
                ST_IN_FLIGHT: begin
                    if (cpl_hit_s[i]) state_d[i] = ST_IDLE;
                    else              state_d[i] = ST_IN_FLIGHT;
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Per-source state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            state_q <= state_d;
        end
    end

    // Offer register: load when empty, freeze while offered, bubble after a handshake.
    always_comb begin
        claim_valid_d = claim_valid_q;
        claim_id_d    = claim_id_q;
        if (hs_s) begin
            claim_valid_d = 1'b0;
        end else if (!claim_valid_q) begin
            claim_valid_d = |pend_s;
            claim_id_d    = lowest_id(pend_s);
        end else begin
            claim_valid_d = 1'b1;
        end
        // The source being claimed this cycle no longer counts towards the level request.
        irq_d     = |(pend_s & ~claim_mask_s);
        cpl_err_d = complete_valid_i & ~(|cpl_hit_s);
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            claim_valid_q <= 1'b0;
            claim_id_q    <= {ID_WIDTH{1'b0}};
            irq_q         <= 1'b0;
            cpl_err_q     <= 1'b0;
        end else begin
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            irq_q         <= irq_d;
            cpl_err_q     <= cpl_err_d;
        end
    end

    assign claim_valid_o = claim_valid_q;
    assign claim_id_o    = claim_id_q;
    assign irq_o         = irq_q;
    assign cpl_err_o     = cpl_err_q;

endmodule
